// File: rtl/alu_muldiv.sv
// alu_muldiv: MIPS execute-stage ALU with an iterative multiply/divide unit and HI/LO registers.
// Define ALU_OVF_EN to build the signed ADD/SUB overflow flag; otherwise ovf is tied low.
//   state  | meaning
//   S_IDLE | waiting for start with a mul/div ctl
//   S_RUN  | one shift-add / restoring-subtract step per cycle, WIDTH cycles
//   S_FIN  | sign correction; HI/LO written on the edge leaving this state
`timescale 1ns/1ps
module alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       ctl,
  input  logic             start,
  input  logic [WIDTH-1:0] data_1,
  input  logic [WIDTH-1:0] data_2,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  localparam logic [3:0] CTL_AND   = 4'b0000;
  localparam logic [3:0] CTL_OR    = 4'b0001;
  localparam logic [3:0] CTL_ADD   = 4'b0010;
  localparam logic [3:0] CTL_SUB   = 4'b0110;
  localparam logic [3:0] CTL_NOR   = 4'b1100;
  localparam logic [3:0] CTL_SLT   = 4'b0111;
  localparam logic [3:0] CTL_MULT  = 4'b1000;
  localparam logic [3:0] CTL_MULTU = 4'b1001;
  localparam logic [3:0] CTL_DIV   = 4'b1010;
  localparam logic [3:0] CTL_DIVU  = 4'b1011;
  localparam logic [3:0] CTL_MFHI  = 4'b1101;
  localparam logic [3:0] CTL_MFLO  = 4'b1110;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   acc_q, acc_d, quo_q, quo_d, opnd_q, opnd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               sa_q, sa_d, sb_q, sb_d;
  logic               div0_q, div0_d;
  logic               done_q, done_d;

  logic               is_md, signed_op, neg_a, neg_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     shifted, diff, sum;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [WIDTH-1:0]   add_res, sub_res;
  logic               slt_lt;

  assign is_md     = (ctl == CTL_MULT) || (ctl == CTL_MULTU) || (ctl == CTL_DIV) || (ctl == CTL_DIVU);
  assign signed_op = (ctl == CTL_MULT) || (ctl == CTL_DIV);
  assign neg_a     = signed_op & data_1[WIDTH-1];
  assign neg_b     = signed_op & data_2[WIDTH-1];
  assign mag_a     = neg_a ? (~data_1 + WIDTH'(1)) : data_1;
  assign mag_b     = neg_b ? (~data_2 + WIDTH'(1)) : data_2;

  // Restoring divide: a clear bit WIDTH in diff means the trial subtraction did not borrow.
  assign shifted = {acc_q, quo_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, opnd_q};
  assign sum     = {1'b0, acc_q} + ({(WIDTH+1){quo_q[0]}} & {1'b0, opnd_q});

  assign prod     = {acc_q, quo_q};
  assign prod_fix = (sa_q ^ sb_q) ? (~prod + (2*WIDTH)'(1)) : prod;
  // Divide by zero leaves the dividend magnitude in acc, so the remainder fix restores data_1.
  assign quo_fix  = div0_q ? '1 : ((sa_q ^ sb_q) ? (~quo_q + WIDTH'(1)) : quo_q);
  assign rem_fix  = sa_q ? (~acc_q + WIDTH'(1)) : acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      acc_q    <= '0;
      quo_q    <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      div0_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      acc_q    <= acc_d;
      quo_q    <= quo_d;
      opnd_q   <= opnd_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      div0_q   <= div0_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    acc_d    = acc_q;
    quo_d    = quo_q;
    opnd_d   = opnd_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    div0_d   = div0_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && is_md) begin
          is_div_d = ctl[1];
          sa_d     = neg_a;
          sb_d     = neg_b;
          div0_d   = ctl[1] && (data_2 == '0);
          acc_d    = '0;
          quo_d    = ctl[1] ? mag_a : mag_b;
          opnd_d   = ctl[1] ? mag_b : mag_a;
          cnt_d    = CNT_W'(WIDTH - 1);
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (is_div_q) begin
          if (!diff[WIDTH]) begin
            acc_d = diff[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = shifted[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_d = sum[WIDTH:1];
          quo_d = {sum[0], quo_q[WIDTH-1:1]};
        end
        if (cnt_q == '0) state_d = S_FIN;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_FIN: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;

  assign add_res = data_1 + data_2;
  assign sub_res = data_1 - data_2;
  assign slt_lt  = $signed(data_1) < $signed(data_2);

  always_comb begin
    res = '0;
    case (ctl)
      CTL_AND:  res = data_1 & data_2;
      CTL_OR:   res = data_1 | data_2;
      CTL_ADD:  res = add_res;
      CTL_SUB:  res = sub_res;
      CTL_NOR:  res = ~(data_1 | data_2);
      CTL_SLT:  res = {{(WIDTH-1){1'b0}}, slt_lt};
      CTL_MFHI: res = hi_q;
      CTL_MFLO: res = lo_q;
      default:  res = '0;
    endcase
  end

  assign zero = (res == '0);

`ifdef ALU_OVF_EN
  logic ovf_add, ovf_sub;
  assign ovf_add = (data_1[WIDTH-1] == data_2[WIDTH-1]) && (add_res[WIDTH-1] != data_1[WIDTH-1]);
  assign ovf_sub = (data_1[WIDTH-1] != data_2[WIDTH-1]) && (sub_res[WIDTH-1] != data_1[WIDTH-1]);
  assign ovf     = ((ctl == CTL_ADD) && ovf_add) || ((ctl == CTL_SUB) && ovf_sub);
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv (WIDTH=32): combinational vector table plus
// scoreboarded multi-cycle mul/div sequences, reset abort and ignored-start cases.
`timescale 1ns/1ps
module tb_alu_muldiv;
  localparam int W = 32;

  localparam logic [3:0] C_AND = 4'b0000, C_OR = 4'b0001, C_ADD = 4'b0010, C_SUB = 4'b0110;
  localparam logic [3:0] C_NOR = 4'b1100, C_SLT = 4'b0111, C_MULT = 4'b1000, C_MULTU = 4'b1001;
  localparam logic [3:0] C_DIV = 4'b1010, C_DIVU = 4'b1011, C_MFHI = 4'b1101, C_MFLO = 4'b1110;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   ctl = 4'b0000;
  logic         start = 1'b0;
  logic [W-1:0] data_1 = '0, data_2 = '0;
  logic [W-1:0] res;
  logic         zero, busy, done, ovf;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0]  sb_q[$];
  logic [W-1:0] model_hi = '0, model_lo = '0;

  alu_muldiv #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .ctl(ctl), .start(start),
    .data_1(data_1), .data_2(data_2),
    .res(res), .zero(zero), .busy(busy), .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] md_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (op)
      C_MULT:  begin p = sa * sb; return p; end
      C_MULTU: begin p = ua * ub; return p; end
      C_DIV: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      C_DIVU: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        p = {(ua % ub), 32'h0} | (ua / ub);
        return p;
      end
      default: return 64'h0;
    endcase
  endfunction

  // Drives a start in the current (or next) negedge, tracks busy/latency, reads HI/LO on done.
  task automatic run_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit mid_start, input bit chk_prior);
    logic [63:0] exp;
    int k, extra;
    @(negedge clk);
    ctl = op; data_1 = a; data_2 = b; start = 1'b1;
    sb_q.push_back(md_model(op, a, b));
    @(posedge clk); #1;
    start = 1'b0;
    k = 1;
    while (!done && k < W + 10) begin
      check("busy_run", busy, 1);
      if (chk_prior && k == 5) begin
        ctl = C_MFLO; #1; check("mflo_old", res, model_lo);
        ctl = C_MFHI; #1; check("mfhi_old", res, model_hi);
      end
      if (mid_start && k == 10) begin
        ctl = C_MULTU; data_1 = 32'd9; data_2 = 32'd9; start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      k++;
    end
    check("done_latency", k, W + 2);
    check("done_pulse", done, 1);
    check("busy_in_done", busy, 0);
    exp = sb_q.pop_front();
    ctl = C_MFHI; #1; check("hi", res, exp[63:32]);
    ctl = C_MFLO; #1; check("lo", res, exp[31:0]);
    model_hi = exp[63:32];
    model_lo = exp[31:0];
    if (mid_start) begin
      extra = 0;
      repeat (40) begin
        @(posedge clk); #1;
        if (done || busy) extra++;
      end
      check("single_done", extra, 0);
    end
  endtask

  typedef struct {
    logic [3:0]  c;
    logic [31:0] a, b, r;
    logic        z, v;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic [3:0] rops[4];
    logic [31:0] ra, rb;
    logic exp_v;

    vecs[0]  = '{C_ADD,   32'd5,         32'd7,         32'd12,        1'b0, 1'b0};
    vecs[1]  = '{C_SUB,   32'd3,         32'd3,         32'd0,         1'b1, 1'b0};
    vecs[2]  = '{C_SLT,   32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0, 1'b0};
    vecs[3]  = '{C_SLT,   32'd1,         32'hFFFF_FFFF, 32'd0,         1'b1, 1'b0};
    vecs[4]  = '{4'b1111, 32'd5,         32'd7,         32'd0,         1'b1, 1'b0};
    vecs[5]  = '{C_AND,   32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0};
    vecs[6]  = '{C_OR,    32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF, 1'b0, 1'b0};
    vecs[7]  = '{C_NOR,   32'h0,         32'h0,         32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[8]  = '{C_ADD,   32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 1'b0, 1'b1};
    vecs[9]  = '{C_SUB,   32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 1'b0, 1'b1};
    vecs[10] = '{C_ADD,   32'd1,         32'd1,         32'd2,         1'b0, 1'b0};
    vecs[11] = '{C_MULT,  32'd6,         32'd7,         32'd0,         1'b1, 1'b0};
    vecs[12] = '{4'b0011, 32'd6,         32'd7,         32'd0,         1'b1, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    ctl = C_MFHI; #1; check("rst_hi", res, 0);
    ctl = C_MFLO; #1; check("rst_lo", res, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      ctl = vecs[i].c; data_1 = vecs[i].a; data_2 = vecs[i].b;
      #1;
`ifdef ALU_OVF_EN
      exp_v = vecs[i].v;
`else
      exp_v = 1'b0;
`endif
      check($sformatf("vec%0d_res", i), res, vecs[i].r);
      check($sformatf("vec%0d_zero", i), zero, vecs[i].z);
      check($sformatf("vec%0d_ovf", i), ovf, exp_v);
    end

    @(negedge clk);
    ctl = C_ADD; data_1 = 32'd1; data_2 = 32'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("nonmd_start_busy", busy, 0);
    @(posedge clk); #1;
    check("nonmd_start_done", done, 0);

    run_md(C_DIVU,  32'd7,         32'd2,         1'b0, 1'b0);
    run_md(C_MULT,  32'hFFFF_FFFD, 32'd5,         1'b0, 1'b1);
    run_md(C_DIV,   32'hFFFF_FFF9, 32'd2,         1'b0, 1'b0);
    run_md(C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_md(C_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_md(C_DIV,   32'hFFFF_FFFB, 32'd0,         1'b0, 1'b0);
    run_md(C_DIVU,  32'd1234,      32'd0,         1'b1, 1'b0);

    rops[0] = C_MULT; rops[1] = C_MULTU; rops[2] = C_DIV; rops[3] = C_DIVU;
    for (int n = 0; n < 6; n++) begin
      ra = $urandom;
      rb = (n % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000));
      run_md(rops[$urandom_range(0, 3)], ra, rb, 1'b0, 1'b0);
    end

    // Reset in the middle of a MULT: immediate abort, HI/LO cleared, no done.
    @(negedge clk);
    ctl = C_MULT; data_1 = 32'h1234_5678; data_2 = 32'h0000_0ABC; start = 1'b1;
    sb_q.push_back(md_model(C_MULT, 32'h1234_5678, 32'h0000_0ABC));
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("busy_before_rst", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    ctl = C_MFHI; #1; check("abort_hi", res, 0);
    ctl = C_MFLO; #1; check("abort_lo", res, 0);
    void'(sb_q.pop_front());
    model_hi = '0;
    model_lo = '0;
    repeat (2) @(posedge clk);
    #1;
    check("abort_no_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_md(C_MULT, 32'd2, 32'd3, 1'b0, 1'b0);

    check("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
